// File: rtl/spawn_scheduler.sv
// spawn_scheduler
//   Paces object spawns for the play field. A 16-bit Fibonacci LFSR supplies
//   a pseudo-random inter-spawn gap (MIN_GAP + lfsr[3:0]) and the lane/type
//   of each offered object. Offers use a valid/ready handshake with the
//   downstream object table. A rising edge on relife reseeds the LFSR from
//   the seed pairs and clears the accepted-spawn counter.
//
// Ports
//   frame_clk    in   1   sole clock, rising edge
//   Reset_n      in   1   synchronous active-low reset
//   game_state   in   3   game FSM state; spawning runs only in PLAY_STATE
//   relife       in   1   level, high during a life restart
//   seed_1       in   2   seed bits, stable while relife is high
//   seed_2       in   2   second seed pair
//   spawn_ready  in   1   downstream accepts the offered spawn
//   spawn_valid  out  1   spawn offer pending
//   spawn_lane   out  2   lane of offered object
//   spawn_type   out  2   type of offered object
//   spawn_count  out  16  accepted spawns since reset or reseed
//   lfsr_state   out  16  current LFSR value (debug)
module spawn_scheduler #(
   parameter logic [2:0] PLAY_STATE = 3'd3,
   parameter logic [7:0] MIN_GAP    = 8'd8
) (
   input  logic        frame_clk,
   input  logic        Reset_n,
   input  logic [2:0]  game_state,
   input  logic        relife,
   input  logic [1:0]  seed_1,
   input  logic [1:0]  seed_2,
   input  logic        spawn_ready,
   output logic        spawn_valid,
   output logic [1:0]  spawn_lane,
   output logic [1:0]  spawn_type,
   output logic [15:0] spawn_count,
   output logic [15:0] lfsr_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      OFFER = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [7:0]  gap_q, gap_d;
   logic        relife_q;
   logic        valid_q, valid_d;
   logic [1:0]  lane_q, lane_d;
   logic [1:0]  type_q, type_d;
   logic [15:0] count_q, count_d;

   logic        reseed;
   logic        in_play;
   logic [15:0] lfsr_step;
   logic [8:0]  gap_sum;
   logic [7:0]  gap_load;

   assign reseed    = relife & ~relife_q;
   assign in_play   = (game_state == PLAY_STATE);
   assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // Ninth bit of the sum flags overflow so the gap saturates instead of wrapping.
   assign gap_sum  = {1'b0, MIN_GAP} + {5'd0, lfsr_q[3:0]};
   assign gap_load = gap_sum[8] ? 8'hFF : gap_sum[7:0];

   // NOTE: every always_comb output gets its hold value first, so no path
   // through the case statement can leave a signal unassigned (no latches).
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      gap_d   = gap_q;
      valid_d = valid_q;
      lane_d  = lane_q;
      type_d  = type_q;
      count_d = count_q;

      if (relife) begin
         // A life restart overrides everything, including a completing handshake.
         state_d = IDLE;
         valid_d = 1'b0;
         if (reseed) begin
            lfsr_d  = {seed_1, seed_2, 12'hACE};
            count_d = 16'd0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_play) begin
                  state_d = WAIT;
                  gap_d   = gap_load;
               end
            end
            WAIT: begin
               if (!in_play) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end else if (gap_q != 8'd0) begin
                  gap_d  = gap_q - 8'd1;
                  lfsr_d = lfsr_step;
               end else begin
                  state_d = OFFER;
                  valid_d = 1'b1;
                  lane_d  = lfsr_q[5:4];
                  type_d  = lfsr_q[7:6];
               end
            end
            OFFER: begin
               if (!in_play) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end else if (spawn_ready) begin
                  // valid is high throughout OFFER, so ready alone completes the transfer.
                  count_d = count_q + 16'd1;
                  valid_d = 1'b0;
                  gap_d   = gap_load;
                  state_d = WAIT;
               end
            end
            default: begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge frame_clk) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         lfsr_q   <= 16'hACE1;
         gap_q    <= 8'd0;
         relife_q <= 1'b0;
         valid_q  <= 1'b0;
         lane_q   <= 2'd0;
         type_q   <= 2'd0;
         count_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         gap_q    <= gap_d;
         relife_q <= relife;
         valid_q  <= valid_d;
         lane_q   <= lane_d;
         type_q   <= type_d;
         count_q  <= count_d;
      end
   end

   assign spawn_valid = valid_q;
   assign spawn_lane  = lane_q;
   assign spawn_type  = type_q;
   assign spawn_count = count_q;
   assign lfsr_state  = lfsr_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler
//   Directed scenarios followed by randomized stimulus. Every clock edge the
//   outputs are compared with a behavioural model of the scheduling rules.
module tb_spawn_scheduler;

   logic        frame_clk = 1'b0;
   logic        Reset_n;
   logic [2:0]  game_state;
   logic        relife;
   logic [1:0]  seed_1;
   logic [1:0]  seed_2;
   logic        spawn_ready;
   logic        spawn_valid;
   logic [1:0]  spawn_lane;
   logic [1:0]  spawn_type;
   logic [15:0] spawn_count;
   logic [15:0] lfsr_state;

   spawn_scheduler dut (
      .frame_clk   (frame_clk),
      .Reset_n     (Reset_n),
      .game_state  (game_state),
      .relife      (relife),
      .seed_1      (seed_1),
      .seed_2      (seed_2),
      .spawn_ready (spawn_ready),
      .spawn_valid (spawn_valid),
      .spawn_lane  (spawn_lane),
      .spawn_type  (spawn_type),
      .spawn_count (spawn_count),
      .lfsr_state  (lfsr_state)
   );

   always #5 frame_clk = ~frame_clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   localparam int PH_IDLE = 0, PH_WAIT = 1, PH_OFFER = 2;
   int m_phase, m_gap, m_lfsr, m_count, m_lane, m_type;
   bit m_valid, m_rel_prev;

   function automatic int next_lfsr(input int v);
      int fb;
      fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
      return ((v * 2) & 16'hFFFF) | fb;
   endfunction

   function automatic int gap_for(input int v);
      int g;
      g = 8 + (v % 16);
      return (g > 255) ? 255 : g;
   endfunction

   task automatic model_step();
      bit play;
      play = (game_state == 3'd3);
      if (!Reset_n) begin
         m_phase = PH_IDLE; m_lfsr = 16'hACE1; m_gap = 0; m_rel_prev = 0;
         m_valid = 0; m_lane = 0; m_type = 0; m_count = 0;
         return;
      end
      if (relife) begin
         if (!m_rel_prev) begin
            m_lfsr  = (int'(seed_1) << 14) + (int'(seed_2) << 12) + 12'hACE;
            m_count = 0;
         end
         m_phase = PH_IDLE;
         m_valid = 0;
      end else if (m_phase == PH_IDLE) begin
         if (play) begin
            m_phase = PH_WAIT;
            m_gap   = gap_for(m_lfsr);
         end
      end else if (!play) begin
         m_phase = PH_IDLE;
         m_valid = 0;
      end else if (m_phase == PH_WAIT) begin
         if (m_gap > 0) begin
            m_gap--;
            m_lfsr = next_lfsr(m_lfsr);
         end else begin
            m_phase = PH_OFFER;
            m_valid = 1;
            m_lane  = (m_lfsr / 16) % 4;
            m_type  = (m_lfsr / 64) % 4;
         end
      end else if (spawn_ready) begin
         m_count = (m_count + 1) % 65536;
         m_valid = 0;
         m_gap   = gap_for(m_lfsr);
         m_phase = PH_WAIT;
      end
      m_rel_prev = relife;
   endtask

   // One rising edge: advance the model with the inputs the DUT sees, then
   // compare all outputs 1 time unit later.
   task automatic tick();
      @(posedge frame_clk);
      model_step();
      #1;
      check("valid", 32'(spawn_valid), 32'(m_valid));
      check("lane",  32'(spawn_lane),  32'(m_lane));
      check("type",  32'(spawn_type),  32'(m_type));
      check("count", 32'(spawn_count), 32'(m_count));
      check("lfsr",  32'(lfsr_state),  32'(m_lfsr));
   endtask

   task automatic wait_model_valid(input string tag);
      int n;
      n = 0;
      while (!m_valid && n < 400) begin
         tick();
         n++;
      end
      if (!m_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic ready_until_count(input int target, input string tag);
      int n;
      n = 0;
      spawn_ready = 1'b1;
      while (m_count != target && n < 2000) begin
         tick();
         n++;
      end
      spawn_ready = 1'b0;
      check(tag, 32'(spawn_count), 32'(target));
   endtask

   initial begin
      int n;
      int frozen;

      Reset_n = 1'b0; game_state = 3'd0; relife = 1'b0;
      seed_1 = 2'b00; seed_2 = 2'b00; spawn_ready = 1'b0;
      tick();
      check("rst_lfsr", 32'(lfsr_state), 32'h0000ACE1);
      check("rst_valid", 32'(spawn_valid), 32'd0);
      Reset_n = 1'b1;
      tick();

      // Reseed with known seeds.
      seed_1 = 2'b01; seed_2 = 2'b10; relife = 1'b1;
      tick();
      check("reseed_lfsr", 32'(lfsr_state), 32'h00006ACE);
      check("reseed_count", 32'(spawn_count), 32'd0);
      relife = 1'b0; game_state = 3'd3;

      // First offer: gap 8+14=22, valid after the 24th edge counting the first play edge.
      n = 0;
      while (!spawn_valid && n < 100) begin
         tick();
         n++;
      end
      check("first_latency", 32'(n), 32'd24);
      for (int i = 0; i < 10; i++) tick();
      check("offer_held", 32'(spawn_valid), 32'd1);

      // Single-cycle handshake.
      spawn_ready = 1'b1;
      tick();
      spawn_ready = 1'b0;
      check("hs_count", 32'(spawn_count), 32'd1);
      check("hs_valid", 32'(spawn_valid), 32'd0);
      n = 0;
      while (!spawn_valid && n < 400) begin
         tick();
         n++;
      end
      check("min_gap_ok", 32'(n >= 9), 32'd1);

      // Reseed, then three back-to-back offers with ready held high.
      relife = 1'b1;
      tick();
      relife = 1'b0;
      tick();
      check("reseed2_count", 32'(spawn_count), 32'd0);
      ready_until_count(3, "three_offers");

      // Leave play during WAIT: LFSR freezes.
      tick();
      game_state = 3'd2;
      tick();
      frozen = m_lfsr;
      for (int i = 0; i < 5; i++) tick();
      check("frozen_lfsr", 32'(lfsr_state), 32'(frozen));
      game_state = 3'd3;
      tick();

      // Collision of reseed with a completing handshake at count 5.
      ready_until_count(5, "count_five");
      wait_model_valid("collision_offer");
      seed_1 = 2'b11; seed_2 = 2'b00;
      relife = 1'b1; spawn_ready = 1'b1;
      tick();
      relife = 1'b0; spawn_ready = 1'b0;
      check("coll_count", 32'(spawn_count), 32'd0);
      check("coll_valid", 32'(spawn_valid), 32'd0);
      check("coll_lfsr", 32'(lfsr_state), 32'h0000CACE);
      tick();

      // Reset in the middle of an offer.
      wait_model_valid("reset_offer");
      Reset_n = 1'b0; spawn_ready = 1'b1; relife = 1'b1;
      tick();
      Reset_n = 1'b1; spawn_ready = 1'b0; relife = 1'b0;
      check("rst2_valid", 32'(spawn_valid), 32'd0);
      check("rst2_lane", 32'(spawn_lane), 32'd0);
      check("rst2_type", 32'(spawn_type), 32'd0);
      check("rst2_count", 32'(spawn_count), 32'd0);
      check("rst2_lfsr", 32'(lfsr_state), 32'h0000ACE1);

      // Randomized phase.
      for (int i = 0; i < 4000; i++) begin
         Reset_n     = ($urandom_range(0, 299) != 0);
         game_state  = ($urandom_range(0, 9) != 0) ? 3'd3 : 3'($urandom_range(0, 7));
         spawn_ready = ($urandom_range(0, 2) == 0);
         if (relife) begin
            relife = ($urandom_range(0, 1) == 0);
         end else begin
            seed_1 = 2'($urandom_range(0, 3));
            seed_2 = 2'($urandom_range(0, 3));
            relife = ($urandom_range(0, 79) == 0);
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
